// File: rtl/onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_rr_arbiter
//  Purpose  : Round-robin arbiter with a registered binary grant index, its
//             one-hot decode, and a hold timer that force-releases long grants.
//  Revision : 1.0 - initial release
// ============================================================================
module onehot_rr_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic [N-1:0]   gnt_onehot,
    output logic           timeout
);

    localparam int                 c_cnt_w     = $clog2(MAX_HOLD);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               r_state;
    logic [IDW-1:0]       r_last;
    logic [c_cnt_w-1:0]   r_hold_cnt;
    logic                 r_gnt_valid;
    logic [IDW-1:0]       r_gnt_id;
    logic                 r_timeout;

    logic                 w_found;
    logic [IDW-1:0]       w_winner;
    logic                 w_owner_req;
    logic                 w_at_limit;
    logic                 w_release;

    // Scan last+1, last+2, ... wrapping; index arithmetic wraps naturally in IDW bits.
    always_comb begin : p_pick
        logic [IDW-1:0] cand;
        w_found  = 1'b0;
        w_winner = '0;
        cand     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = r_last + IDW'(k);
            if (!w_found && req[cand]) begin
                w_found  = 1'b1;
                w_winner = cand;
            end
        end
    end

    assign w_owner_req = req[r_gnt_id];
    assign w_at_limit  = (r_hold_cnt == c_hold_last);
    assign w_release   = done || !w_owner_req || w_at_limit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last      <= IDW'(N - 1);
            r_hold_cnt  <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state     <= S_GRANT;
                        r_gnt_valid <= 1'b1;
                        r_gnt_id    <= w_winner;
                        r_last      <= w_winner;
                        r_hold_cnt  <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_state     <= S_IDLE;
                        r_gnt_valid <= 1'b0;
                        // Only a pure timer expiry is flagged; done or a dropped request win.
                        r_timeout   <= w_at_limit && !done && w_owner_req;
                    end else begin
                        r_hold_cnt  <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt_valid  = r_gnt_valid;
    assign gnt_id     = r_gnt_id;
    assign gnt_onehot = r_gnt_valid ? (N'(1) << r_gnt_id) : '0;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onehot_rr_arbiter
//  Purpose  : Directed and random stimulus for onehot_rr_arbiter, compared
//             against a cycle-level behavioural model of the arbitration rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_rr_arbiter;

    localparam int N        = 8;
    localparam int IDW      = 3;
    localparam int MAX_HOLD = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic           done;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   gnt_onehot;
    logic           timeout;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_valid;
    int m_id;
    int m_last;
    int m_held;
    bit m_to;

    onehot_rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id),
        .gnt_onehot (gnt_onehot),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic tick();
        int  w;
        bit  by_done, by_drop, by_timer;
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_id = 0; m_last = N - 1; m_held = 0; m_to = 0;
        end else if (!m_valid) begin
            m_to = 0;
            w = rr_pick(req, m_last);
            if (w >= 0) begin
                m_valid = 1; m_id = w; m_last = w; m_held = 1;
            end
        end else begin
            m_to     = 0;
            by_done  = done;
            by_drop  = !req[m_id];
            by_timer = (m_held == MAX_HOLD);
            if (by_done || by_drop || by_timer) begin
                m_valid = 0;
                m_to    = by_timer && !by_done && !by_drop;
            end else begin
                m_held++;
            end
        end
        #1;
        check("gnt_valid",  32'(gnt_valid),  32'(m_valid));
        check("gnt_id",     32'(gnt_id),     32'(m_id));
        check("gnt_onehot", 32'(gnt_onehot), m_valid ? (32'd1 << m_id) : 32'd0);
        check("timeout",    32'(timeout),    32'(m_to));
        check("onehot_pop", 32'($countones(gnt_onehot) <= 1), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; done = 1'b0;
        m_valid = 0; m_id = 0; m_last = N - 1; m_held = 0; m_to = 0;
        #2;

        // 1: idle after reset
        do_reset();
        repeat (5) tick();
        check("t1_idle_valid", 32'(gnt_valid), 32'd0);

        // 2: single requester, done in third grant cycle
        req = 8'h01;
        tick();
        check("t2_first_onehot", 32'(gnt_onehot), 32'h01);
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0; req = 8'h00;
        check("t2_released", 32'(gnt_valid), 32'd0);
        tick();

        // 3: fairness with all requesting
        do_reset();
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            tick();
            check("t3_seq_id", 32'(gnt_id), 32'(g % N));
            check("t3_seq_oh", 32'(gnt_onehot), 32'd1 << (g % N));
            done = 1'b1;
            tick();
            done = 1'b0;
            check("t3_gap", 32'(gnt_valid), 32'd0);
        end

        // 4: hold timeout alternates between 2 and 5
        do_reset();
        req = 8'h24;
        tick();
        check("t4_id2", 32'(gnt_id), 32'd2);
        repeat (MAX_HOLD - 1) tick();
        check("t4_still_held", 32'(gnt_valid), 32'd1);
        tick();
        check("t4_timeout", 32'(timeout), 32'd1);
        tick();
        check("t4_id5", 32'(gnt_id), 32'd5);
        check("t4_to_clear", 32'(timeout), 32'd0);
        repeat (MAX_HOLD) tick();
        check("t4_timeout2", 32'(timeout), 32'd1);
        tick();
        check("t4_id2_again", 32'(gnt_id), 32'd2);

        // 5: request drop mid-grant
        do_reset();
        req = 8'h88;
        tick();
        check("t5_id3", 32'(gnt_id), 32'd3);
        tick();
        req = 8'h80;
        tick();
        check("t5_drop_rel", 32'(gnt_valid), 32'd0);
        check("t5_no_to", 32'(timeout), 32'd0);
        tick();
        check("t5_oh80", 32'(gnt_onehot), 32'h80);

        // 6: reset during grant restores pointer
        do_reset();
        req = 8'h40;
        tick();
        check("t6_id6", 32'(gnt_id), 32'd6);
        rst_n = 1'b0;
        tick();
        check("t6_rst_oh", 32'(gnt_onehot), 32'h00);
        rst_n = 1'b1; req = 8'h41;
        tick();
        check("t6_id0", 32'(gnt_id), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            done  = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
